// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - register file port arbiter between core and debug requester
module regfile_arbiter #(
   parameter int DBG_MAX_WAIT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       core_wr_en,
   input  logic [3:0] core_wr_sel,
   input  logic [7:0] core_wr_data,
   input  logic       core_inc,
   input  logic       core_dec,
   input  logic [3:0] core_ptr_sel,
   output logic       core_stall,
   input  logic       dbg_valid,
   input  logic       dbg_we,
   input  logic [3:0] dbg_addr,
   input  logic [7:0] dbg_wdata,
   output logic       dbg_ready,
   output logic       dbg_rvalid,
   output logic [7:0] dbg_rdata,
   output logic [3:0] rf_inSelect,
   output logic [3:0] rf_outBselect,
   output logic [7:0] rf_in,
   output logic       rf_write_en,
   output logic       rf_inc,
   output logic       rf_dec,
   input  logic [7:0] rf_outA
);

   typedef enum logic {
      IDLE   = 1'b0,
      REPLAY = 1'b1
   } state_t;

   localparam logic [7:0] MAX_WAIT = 8'(DBG_MAX_WAIT);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic       core_req;
   logic       core_ptr_op;
   logic       conflict;
   logic       force_grant;
   logic       accept;
   logic [3:0] pair_lo;
   logic [3:0] pair_hi;

   // pointer pair {2p+1, 2p} wraps modulo 16, so only the low three select bits matter
   assign pair_lo     = {core_ptr_sel[2:0], 1'b0};
   assign pair_hi     = {core_ptr_sel[2:0], 1'b1};
   assign core_ptr_op = core_inc | core_dec;
   assign core_req    = core_wr_en | core_ptr_op;
   assign conflict    = core_wr_en & core_ptr_op &
                        ((core_wr_sel == core_ptr_sel) |
                         (core_wr_sel == pair_lo) |
                         (core_wr_sel == pair_hi));
   assign force_grant = dbg_valid & (wait_cnt == MAX_WAIT);
   assign accept      = dbg_valid & dbg_ready;

   // next-state selection and register file port steering
   always_comb begin
      state_nxt     = state;
      rf_inSelect   = core_wr_sel;
      rf_outBselect = core_ptr_sel;
      rf_in         = core_wr_data;
      rf_write_en   = 1'b0;
      rf_inc        = 1'b0;
      rf_dec        = 1'b0;
      dbg_ready     = 1'b0;
      core_stall    = 1'b0;
      if (!rst) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (force_grant || (dbg_valid && !core_req)) begin
                  dbg_ready   = 1'b1;
                  core_stall  = force_grant & core_req;
                  rf_inSelect = dbg_addr;
                  if (dbg_we) begin
                     rf_write_en = 1'b1;
                     rf_in       = dbg_wdata;
                  end
               end else if (conflict) begin
                  rf_write_en = 1'b1;
                  core_stall  = 1'b1;
                  state_nxt   = REPLAY;
               end else if (core_req) begin
                  rf_write_en = core_wr_en;
                  rf_inc      = core_inc;
                  rf_dec      = core_dec & ~core_inc;
               end
            end
            REPLAY: begin
               rf_inc    = core_inc;
               rf_dec    = core_dec & ~core_inc;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // state, debug read capture and starvation counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         wait_cnt   <= 8'd0;
         dbg_rvalid <= 1'b0;
         dbg_rdata  <= 8'd0;
      end else begin
         state      <= state_nxt;
         dbg_rvalid <= accept & ~dbg_we;
         if (accept && !dbg_we) begin
            dbg_rdata <= rf_outA;
         end
         if (accept || !dbg_valid) begin
            wait_cnt <= 8'd0;
         end else if (wait_cnt != MAX_WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - scoreboard bench for regfile_arbiter with a 16x8 register file model
module tb_regfile_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       core_wr_en;
   logic [3:0] core_wr_sel;
   logic [7:0] core_wr_data;
   logic       core_inc;
   logic       core_dec;
   logic [3:0] core_ptr_sel;
   logic       core_stall;
   logic       dbg_valid;
   logic       dbg_we;
   logic [3:0] dbg_addr;
   logic [7:0] dbg_wdata;
   logic       dbg_ready;
   logic       dbg_rvalid;
   logic [7:0] dbg_rdata;
   logic [3:0] rf_inSelect;
   logic [3:0] rf_outBselect;
   logic [7:0] rf_in;
   logic       rf_write_en;
   logic       rf_inc;
   logic       rf_dec;
   logic [7:0] rf_outA;

   logic [7:0] regs [16];

   typedef struct {
      string      name;
      logic       we;
      logic       inc;
      logic       dec;
      logic       stall;
      logic       rdy;
      logic [3:0] insel;
      logic [3:0] outb;
      logic [7:0] din;
   } exp_t;

   exp_t       cyc_q [$];
   logic [7:0] rd_q  [$];
   int         checks   = 0;
   int         failures = 0;

   regfile_arbiter #(.DBG_MAX_WAIT(8)) dut (
      .clk(clk), .rst(rst),
      .core_wr_en(core_wr_en), .core_wr_sel(core_wr_sel), .core_wr_data(core_wr_data),
      .core_inc(core_inc), .core_dec(core_dec), .core_ptr_sel(core_ptr_sel),
      .core_stall(core_stall),
      .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .rf_inSelect(rf_inSelect), .rf_outBselect(rf_outBselect), .rf_in(rf_in),
      .rf_write_en(rf_write_en), .rf_inc(rf_inc), .rf_dec(rf_dec), .rf_outA(rf_outA)
   );

   always #5 clk = ~clk;

   // register file model: combinational port A, write and pointer-pair inc/dec at the edge
   assign rf_outA = regs[rf_inSelect];
   always @(posedge clk) begin
      logic [3:0]  lo;
      logic [15:0] pair;
      lo   = {rf_outBselect[2:0], 1'b0};
      pair = {regs[lo | 4'd1], regs[lo]};
      if (rf_write_en) regs[rf_inSelect] <= rf_in;
      if (rf_inc || rf_dec) begin
         pair = rf_inc ? pair + 16'd1 : pair - 16'd1;
         regs[lo | 4'd1] <= pair[15:8];
         regs[lo]        <= pair[7:0];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input string name, input logic we, input logic inc, input logic dec,
                       input logic stall, input logic rdy, input logic [3:0] insel,
                       input logic [3:0] outb, input logic [7:0] din);
      exp_t e;
      e.name = name; e.we = we; e.inc = inc; e.dec = dec; e.stall = stall; e.rdy = rdy;
      e.insel = insel; e.outb = outb; e.din = din;
      cyc_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic core_set(input logic we, input logic [3:0] sel, input logic [7:0] data,
                           input logic inc, input logic dec, input logic [3:0] ptr);
      core_wr_en = we; core_wr_sel = sel; core_wr_data = data;
      core_inc = inc; core_dec = dec; core_ptr_sel = ptr;
   endtask

   task automatic dbg_set(input logic v, input logic we, input logic [3:0] a, input logic [7:0] d);
      dbg_valid = v; dbg_we = we; dbg_addr = a; dbg_wdata = d;
   endtask

   task automatic idle(input string name);
      core_set(0, 0, 0, 0, 0, 0);
      dbg_set(0, 0, 0, 0);
      step(name, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic dbg_write(input logic [3:0] a, input logic [7:0] d);
      dbg_set(1, 1, a, d);
      step("dbg_write", 1, 0, 0, 0, 1, a, 0, d);
      dbg_set(0, 0, 0, 0);
   endtask

   task automatic dbg_read(input logic [3:0] a, input logic [7:0] exp);
      dbg_set(1, 0, a, 0);
      rd_q.push_back(exp);
      step("dbg_read", 0, 0, 0, 0, 1, a, 0, 0);
      dbg_set(0, 0, 0, 0);
   endtask

   // monitor: compare per-cycle port activity and read responses against the queues
   always @(negedge clk) begin
      exp_t e;
      if (cyc_q.size() != 0) begin
         e = cyc_q.pop_front();
         check({e.name, ".rf_write_en"}, rf_write_en, e.we);
         check({e.name, ".rf_inc"}, rf_inc, e.inc);
         check({e.name, ".rf_dec"}, rf_dec, e.dec);
         check({e.name, ".core_stall"}, core_stall, e.stall);
         check({e.name, ".dbg_ready"}, dbg_ready, e.rdy);
         if (e.we || e.rdy) check({e.name, ".rf_inSelect"}, rf_inSelect, e.insel);
         if (e.we) check({e.name, ".rf_in"}, rf_in, e.din);
         if (e.inc || e.dec) check({e.name, ".rf_outBselect"}, rf_outBselect, e.outb);
      end
      if (dbg_rvalid) begin
         if (rd_q.size() == 0) begin
            check("rvalid_unexpected", 1, 0);
         end else begin
            check("dbg_rdata", dbg_rdata, rd_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      core_set(1, 4, 8'h12, 1, 0, 2);
      dbg_set(1, 1, 3, 8'h99);
      @(posedge clk);
      #1;
      // reset with requests pending: every strobe forced low
      step("reset0", 0, 0, 0, 0, 0, 0, 0, 0);
      step("reset1", 0, 0, 0, 0, 0, 0, 0, 0);
      check("reset.dbg_rvalid", dbg_rvalid, 0);
      check("reset.dbg_rdata", dbg_rdata, 0);
      rst = 1'b1;
      idle("idle0");

      // preload through the debug port
      dbg_write(4, 8'hFF);
      dbg_write(5, 8'h00);
      dbg_write(3, 8'hA5);
      dbg_write(2, 8'hFF);
      dbg_write(15, 8'h20);
      idle("idle1");

      // debug read with core idle: one-cycle rvalid pulse next cycle
      dbg_read(3, 8'hA5);
      idle("rd_pulse");
      idle("rd_after");

      // conflict split: write 0x55 to reg 4, then inc pair 5:4 -> 0x0056
      core_set(1, 4, 8'h55, 1, 0, 2);
      step("conflict_wr", 1, 0, 0, 1, 0, 4, 0, 8'h55);
      step("conflict_replay", 0, 1, 0, 0, 0, 0, 2, 0);
      idle("conflict_done");
      check("pair54.hi", regs[5], 8'h00);
      check("pair54.lo", regs[4], 8'h56);
      dbg_read(4, 8'h56);
      idle("idle2");

      // non-conflict pass-through: write reg 7 and inc pair 3:2 together
      core_set(1, 7, 8'h3C, 1, 0, 1);
      step("pass_through", 1, 1, 0, 0, 0, 7, 1, 8'h3C);
      idle("no_replay");
      check("reg7", regs[7], 8'h3C);
      check("pair32.hi", regs[3], 8'hA6);
      check("pair32.lo", regs[2], 8'h00);

      // inc wins over dec, then dec alone
      core_set(0, 0, 0, 1, 1, 1);
      step("inc_over_dec", 0, 1, 0, 0, 0, 0, 1, 0);
      core_set(0, 0, 0, 0, 1, 1);
      step("dec_only", 0, 0, 1, 0, 0, 0, 1, 0);
      idle("idle3");
      check("pair32.after_incdec", regs[2], 8'h00);

      // pair index wraps: ptr 9 selects regs 3:2, so a write to reg 2 conflicts
      core_set(1, 2, 8'h10, 0, 1, 9);
      step("wrap_conflict_wr", 1, 0, 0, 1, 0, 2, 0, 8'h10);
      step("wrap_conflict_dec", 0, 0, 1, 0, 0, 0, 9, 0);
      idle("idle4");
      check("wrap.lo", regs[2], 8'h0F);
      check("wrap.hi", regs[3], 8'hA6);

      // starvation: 8 refusals then a forced grant, twice (counter restarts from 0)
      core_set(1, 8, 8'h11, 0, 0, 0);
      dbg_set(1, 0, 7, 0);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 8; i++) begin
            step("starve_wait", 1, 0, 0, 0, 0, 8, 0, 8'h11);
         end
         rd_q.push_back(8'h3C);
         step("starve_force", 0, 0, 0, 1, 1, 7, 0, 0);
      end
      dbg_set(0, 0, 0, 0);
      step("starve_resume", 1, 0, 0, 0, 0, 8, 0, 8'h11);
      idle("idle5");

      // debug request raised during REPLAY is held off one cycle
      core_set(1, 12, 8'h01, 1, 0, 6);
      step("replay_dbg_wr", 1, 0, 0, 1, 0, 12, 0, 8'h01);
      dbg_set(1, 1, 10, 8'h77);
      step("replay_dbg_refused", 0, 1, 0, 0, 0, 0, 6, 0);
      core_set(0, 0, 0, 0, 0, 0);
      step("replay_dbg_granted", 1, 0, 0, 0, 1, 10, 0, 8'h77);
      dbg_set(0, 0, 0, 0);
      idle("idle6");
      check("reg10", regs[10], 8'h77);

      // reset in the REPLAY cycle abandons the pending dec
      core_set(1, 14, 8'hAA, 0, 1, 7);
      step("rst_replay_wr", 1, 0, 0, 1, 0, 14, 0, 8'hAA);
      rst = 1'b0;
      step("rst_replay_cut", 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_replay.dbg_rvalid", dbg_rvalid, 0);
      check("rst_replay.dbg_rdata", dbg_rdata, 0);
      check("rst_replay.reg14", regs[14], 8'hAA);
      check("rst_replay.reg15", regs[15], 8'h20);
      rst = 1'b1;
      step("post_rst_conflict", 1, 0, 0, 1, 0, 14, 0, 8'hAA);
      step("post_rst_replay", 0, 0, 1, 0, 0, 0, 7, 0);
      idle("idle7");
      check("post_rst.reg14", regs[14], 8'hA9);
      check("post_rst.reg15", regs[15], 8'h20);
      idle("idle8");

      @(negedge clk);
      #1;
      check("cycle_queue_drained", cyc_q.size(), 0);
      check("read_queue_drained", rd_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Sits between the CPU core and the 16x8 register file.
- Shares the file's single write/inc/dec port between the core and a debug requester that uses a valid/ready handshake.
- Serializes a core write that collides with a same-cycle pointer inc/dec, which the register file would otherwise silently drop.
- Bounds debug starvation with a wait counter.

Parameters:
- DBG_MAX_WAIT, 8: number of cycles a pending debug request may be refused before the core is force-stalled for one cycle. Legal range 1..255.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- core_wr_en  in  1  core register write request.
- core_wr_sel  in  4  core write register index.
- core_wr_data  in  8  core write data.
- core_inc  in  1  core pointer-pair increment request.
- core_dec  in  1  core pointer-pair decrement request. Ignored when core_inc is high.
- core_ptr_sel  in  4  pointer select. Pair = registers {2p+1, 2p}, indices mod 16.
- core_stall  out  1  core must hold all core_* inputs unchanged next cycle.
- dbg_valid  in  1  debug request pending.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  4  debug register index.
- dbg_wdata  in  8  debug write data.
- dbg_ready  out  1  debug request accepted this cycle, when dbg_valid is also high.
- dbg_rvalid  out  1  one-cycle pulse, dbg_rdata valid.
- dbg_rdata  out  8  registered debug read data.
- rf_inSelect  out  4  to register file write/read-A select.
- rf_outBselect  out  4  to register file pointer select.
- rf_in  out  8  to register file write data.
- rf_write_en, rf_inc, rf_dec  out  1 each  to register file.
- rf_outA  in  8  register file port A, combinational read of rf_inSelect.

Behaviour:
Reset (rst low at a rising edge):
- state <= IDLE, wait_cnt <= 0, dbg_rvalid <= 0, dbg_rdata <= 0.
- While rst is low, all combinational outputs are forced to 0: rf_write_en, rf_inc, rf_dec, dbg_ready, core_stall.
- Reset overrides a REPLAY in progress. The replayed inc/dec is abandoned.

Definitions:
- core_req = core_wr_en | core_inc | core_dec.
- conflict = core_wr_en & (core_inc | core_dec) & (core_wr_sel == core_ptr_sel | core_wr_sel == 2p | core_wr_sel == 2p+1), with p = core_ptr_sel and arithmetic mod 16.
- force = dbg_valid & (wait_cnt == DBG_MAX_WAIT).

State IDLE, priority order:
1. force:
   - Debug is granted: dbg_ready = 1, core_stall = core_req.
   - No core operation is issued this cycle.
2. dbg_valid & ~core_req:
   - Debug is granted: dbg_ready = 1.
3. conflict:
   - Issue the write only: rf_write_en = 1, rf_inSelect = core_wr_sel, rf_in = core_wr_data.
   - core_stall = 1; next state REPLAY.
4. core_req:
   - Pass through in one cycle: rf_write_en = core_wr_en, rf_inc = core_inc, rf_dec = core_dec & ~core_inc, selects and data from core_*.
   - core_stall = 0.
5. Otherwise all rf strobes are 0.

State REPLAY:
- Issue only the inc/dec from the held core inputs: rf_inc / rf_dec, rf_outBselect = core_ptr_sel, rf_write_en = 0.
- core_stall = 0 and dbg_ready = 0.
- Next state IDLE unconditionally.

Debug grant cycle:
- Write: rf_write_en = 1, rf_inSelect = dbg_addr, rf_in = dbg_wdata. dbg_rvalid <= 0.
- Read: rf_inSelect = dbg_addr, no strobes. At the edge, dbg_rdata <= rf_outA and dbg_rvalid <= 1, so the pulse appears the cycle after acceptance (latency 1).
- Debug read of a register the core wrote in the previous cycle returns the new value.

Between grants:
- dbg_rvalid <= 0 on every edge without a read accept.
- dbg_rdata holds its last value.

wait_cnt:
- Cleared on any accept.
- Otherwise increments when dbg_valid & ~dbg_ready, saturating at DBG_MAX_WAIT.
- Cleared when dbg_valid is low.

Selects when no operation is issued: rf_inSelect = core_wr_sel, rf_outBselect = core_ptr_sel, rf_in = core_wr_data.

Test Plan:
1. Conflict split:
   - Stimulus: core_wr_en = 1, wr_sel = 4, data = 0x55, core_inc = 1, ptr_sel = 2; regs 5:4 = 0x00FF.
   - Cycle 0: rf_write_en only, core_stall = 1.
   - Cycle 1: rf_inc only, stall = 0.
   - Final regs 5:4 = 0x0056.
2. Non-conflict pass-through:
   - Stimulus: wr_sel = 7, ptr_sel = 1, inc.
   - Write and inc issue in the same cycle, no stall, no REPLAY.
3. Debug read when core idle:
   - Stimulus: reg 3 = 0xA5; dbg_valid = 1, dbg_we = 0, addr = 3.
   - dbg_ready = 1 in the same cycle; dbg_rvalid = 1 with dbg_rdata = 0xA5 next cycle, for exactly one cycle.
4. Starvation:
   - Stimulus: core_wr_en held high, dbg_valid high from cycle 0, DBG_MAX_WAIT = 8.
   - dbg_ready = 0 for cycles 0..7.
   - Cycle 8: dbg_ready = 1, core_stall = 1, no core write.
   - Cycle 9: core write proceeds, wait_cnt = 0.
5. Debug write during REPLAY:
   - Stimulus: dbg_valid asserted in the REPLAY cycle.
   - dbg_ready = 0 in REPLAY; granted the next cycle if the core is idle.
6. Reset mid-REPLAY:
   - Stimulus: rst = 0 during REPLAY.
   - No rf_inc issued; state IDLE; dbg_rvalid = 0 and dbg_rdata = 0x00 after the edge.
